// File: rtl/vc_ingress_buffer_pkg.sv
// Shared constants and helpers for the virtual-channel ingress buffer.
// Holds the default geometry, the depth and count-width formulas, and the VC field decode.
package vc_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_NUM_VC     = 2;
  localparam int DEF_ADDR_WIDTH = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so that a completely full FIFO is distinguishable from an empty one.
  function automatic int cnt_w_of(input int addr_width);
    return addr_width + 1;
  endfunction

  // The VC number is carried in the top sel_w bits of the word.
  function automatic int unsigned vc_field(input logic [63:0] word, input int data_width,
                                           input int sel_w);
    logic [63:0] sh;
    logic [63:0] mask;
    sh   = word >> (data_width - sel_w);
    mask = (64'd1 << sel_w) - 64'd1;
    return 32'(sh & mask);
  endfunction

endpackage

// File: rtl/vc_ingress_buffer_if.sv
// Handshake and status bundle between the upstream source (master) and the ingress buffer (slave).
interface vc_ingress_buffer_if #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC     = 2,
  parameter int ADDR_WIDTH = 2
);
  logic                         wr_enable;
  logic [DATA_WIDTH-1:0]        data_in;
  logic [NUM_VC-1:0]            pop;
  logic [ADDR_WIDTH:0]          umbral_almost_full;
  logic [ADDR_WIDTH:0]          umbral_almost_empty;
  logic [NUM_VC*DATA_WIDTH-1:0] data_out;
  logic [NUM_VC-1:0]            full;
  logic [NUM_VC-1:0]            empty;
  logic [NUM_VC-1:0]            almost_full;
  logic [NUM_VC-1:0]            almost_empty;
  logic [NUM_VC-1:0]            error;
  logic                         pause;

  modport master (
    output wr_enable, data_in, pop, umbral_almost_full, umbral_almost_empty,
    input  data_out, full, empty, almost_full, almost_empty, error, pause
  );

  modport slave (
    input  wr_enable, data_in, pop, umbral_almost_full, umbral_almost_empty,
    output data_out, full, empty, almost_full, almost_empty, error, pause
  );
endinterface

// File: rtl/vc_ingress_buffer_fifo_param.sv
// One synchronous FIFO with occupancy flags, sticky overflow/underflow error and a registered read port.
module fifo_param
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH:0]   umbral_almost_full,
  input  logic [ADDR_WIDTH:0]   umbral_almost_empty,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  almost_full_nxt,
  output logic                  error
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CNT_W = cnt_w_of(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  is_full, is_empty, push_ok, pop_ok;

  always_comb begin
    is_full  = (count_q == DEPTH_C);
    is_empty = (count_q == '0);
    pop_ok   = pop && !is_empty;
    // A full FIFO still takes a push when the same edge frees a slot.
    push_ok  = push && (!is_full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if ((push && !push_ok) || (pop && is_empty)) error_d = 1'b1;
    almost_full_nxt = (count_d >= umbral_almost_full);
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Flags follow the registered count, so thresholds act on them immediately.
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (count_q >= umbral_almost_full);
  assign almost_empty = (count_q <= umbral_almost_empty);
  assign rdata        = rdata_q;
  assign error        = error_q;

endmodule

// File: rtl/vc_ingress_buffer.sv
// Ingress stage: steers each word to the FIFO named by its VC field and throttles the source via pause.
module vc_ingress_buffer
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_VC     = DEF_NUM_VC,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic              clk,
  input logic              reset,
  vc_ingress_buffer_if.slave bus
);
  localparam int VC_SEL_W = $clog2(NUM_VC);

  logic [VC_SEL_W-1:0]          vc_sel;
  logic [NUM_VC-1:0]            push_vec;
  logic [NUM_VC-1:0]            af_nxt;
  logic [NUM_VC*DATA_WIDTH-1:0] data_out_w;
  logic [NUM_VC-1:0]            full_w, empty_w, af_w, ae_w, error_w;
  logic                         pause_q, pause_d;

  always_comb begin
    vc_sel   = VC_SEL_W'(vc_field(64'(bus.data_in), DATA_WIDTH, VC_SEL_W));
    push_vec = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      push_vec[k] = bus.wr_enable && (vc_sel == VC_SEL_W'(k));
    end
    pause_d = |af_nxt;
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    fifo_param #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
      .clk                (clk),
      .reset              (reset),
      .push               (push_vec[g]),
      .pop                (bus.pop[g]),
      .wdata              (bus.data_in),
      .umbral_almost_full (bus.umbral_almost_full),
      .umbral_almost_empty(bus.umbral_almost_empty),
      .rdata              (data_out_w[g*DATA_WIDTH +: DATA_WIDTH]),
      .full               (full_w[g]),
      .empty              (empty_w[g]),
      .almost_full        (af_w[g]),
      .almost_empty       (ae_w[g]),
      .almost_full_nxt    (af_nxt[g]),
      .error              (error_w[g])
    );
  end

  // pause is registered from next-state almost_full so it rises together with the flag.
  always_ff @(posedge clk) begin
    if (!reset) pause_q <= 1'b0;
    else        pause_q <= pause_d;
  end

  assign bus.data_out     = data_out_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = af_w;
  assign bus.almost_empty = ae_w;
  assign bus.error        = error_w;
  assign bus.pause        = pause_q;

endmodule

// File: tb/tb_vc_ingress_buffer.sv
// Directed bench for the ingress buffer: a default 2-VC instance and a 4-VC, depth-8 instance.
module tb_vc_ingress_buffer;
  logic clk = 1'b0;
  logic rst2_n;
  logic rst4_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vc_ingress_buffer_if #(.DATA_WIDTH(6), .NUM_VC(2), .ADDR_WIDTH(2)) bus2 ();
  vc_ingress_buffer_if #(.DATA_WIDTH(8), .NUM_VC(4), .ADDR_WIDTH(3)) bus4 ();

  vc_ingress_buffer #(.DATA_WIDTH(6), .NUM_VC(2), .ADDR_WIDTH(2)) u_dut2 (
    .clk  (clk),
    .reset(rst2_n),
    .bus  (bus2)
  );

  vc_ingress_buffer #(.DATA_WIDTH(8), .NUM_VC(4), .ADDR_WIDTH(3)) u_dut4 (
    .clk  (clk),
    .reset(rst4_n),
    .bus  (bus4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [5:0] w);
    bus2.wr_enable = 1'b1;
    bus2.data_in   = w;
    tick();
    bus2.wr_enable = 1'b0;
  endtask

  task automatic pop2(input logic [1:0] p);
    bus2.pop = p;
    tick();
    bus2.pop = 2'b00;
  endtask

  task automatic push4(input logic [7:0] w);
    bus4.wr_enable = 1'b1;
    bus4.data_in   = w;
    tick();
    bus4.wr_enable = 1'b0;
  endtask

  initial begin
    logic [5:0] exp_w [4];
    rst2_n = 1'b0;
    rst4_n = 1'b0;
    bus2.wr_enable = 1'b0; bus2.data_in = '0; bus2.pop = '0;
    bus2.umbral_almost_full = 3'd3; bus2.umbral_almost_empty = 3'd0;
    bus4.wr_enable = 1'b0; bus4.data_in = '0; bus4.pop = '0;
    bus4.umbral_almost_full = 4'd8; bus4.umbral_almost_empty = 4'd1;

    tick(); tick();
    chk("rst_empty", bus2.empty, 2'b11);
    chk("rst_ae", bus2.almost_empty, 2'b11);
    chk("rst_full", bus2.full, 2'b00);
    chk("rst_af", bus2.almost_full, 2'b00);
    chk("rst_err", bus2.error, 2'b00);
    chk("rst_dout", bus2.data_out, 12'h000);
    chk("rst_pause", bus2.pause, 1'b0);

    rst2_n = 1'b1;
    tick();
    push2(6'b0_00101);
    push2(6'b1_00111);
    chk("two_vc_not_empty", bus2.empty, 2'b00);
    pop2(2'b11);
    chk("pop_both_dout", bus2.data_out, {6'h27, 6'h05});
    chk("pop_both_empty", bus2.empty, 2'b11);

    // Fill VC0 to the almost-full threshold and beyond.
    push2(6'h01);
    push2(6'h02);
    chk("af_after2", bus2.almost_full, 2'b00);
    chk("pause_after2", bus2.pause, 1'b0);
    push2(6'h03);
    chk("af_after3", bus2.almost_full, 2'b01);
    chk("pause_after3", bus2.pause, 1'b1);
    chk("full_after3", bus2.full, 2'b00);
    push2(6'h04);
    chk("full_after4", bus2.full, 2'b01);
    chk("ae_when_full", bus2.almost_empty, 2'b10);

    // Threshold above depth disables almost_full immediately.
    bus2.umbral_almost_full = 3'd5;
    #1;
    chk("af_thr_gt_depth", bus2.almost_full, 2'b00);
    bus2.umbral_almost_full = 3'd3;
    #1;

    // Push and pop together on a full FIFO.
    bus2.wr_enable = 1'b1; bus2.data_in = 6'h05; bus2.pop = 2'b01;
    tick();
    bus2.wr_enable = 1'b0; bus2.pop = 2'b00;
    chk("pp_full_dout", bus2.data_out[5:0], 6'h01);
    chk("pp_full_full", bus2.full, 2'b01);
    chk("pp_full_err", bus2.error, 2'b00);

    push2(6'h06);
    chk("ovf_err", bus2.error, 2'b01);
    chk("ovf_full", bus2.full, 2'b01);

    exp_w[0] = 6'h02; exp_w[1] = 6'h03; exp_w[2] = 6'h04; exp_w[3] = 6'h05;
    for (int i = 0; i < 4; i++) begin
      pop2(2'b01);
      chk($sformatf("drain1_%0d", i), bus2.data_out[5:0], exp_w[i]);
    end
    chk("drain1_empty", bus2.empty, 2'b11);
    chk("drain1_pause", bus2.pause, 1'b0);

    // Second fill crosses the pointer wrap.
    push2(6'h0A); push2(6'h0B); push2(6'h0C); push2(6'h0D);
    exp_w[0] = 6'h0A; exp_w[1] = 6'h0B; exp_w[2] = 6'h0C; exp_w[3] = 6'h0D;
    for (int i = 0; i < 4; i++) begin
      pop2(2'b01);
      chk($sformatf("drain2_%0d", i), bus2.data_out[5:0], exp_w[i]);
    end

    // Underflow on VC1.
    pop2(2'b10);
    chk("udf_err", bus2.error, 2'b11);
    chk("udf_dout_vc1", bus2.data_out[11:6], 6'h27);
    tick(); tick(); tick();
    chk("udf_sticky", bus2.error[1], 1'b1);

    // Push and pop together on an empty VC: pop underflows, push lands.
    bus2.wr_enable = 1'b1; bus2.data_in = 6'b1_01010; bus2.pop = 2'b10;
    tick();
    bus2.wr_enable = 1'b0; bus2.pop = 2'b00;
    chk("pp_empty_notempty", bus2.empty, 2'b01);
    chk("pp_empty_dout", bus2.data_out[11:6], 6'h27);
    pop2(2'b10);
    chk("pp_empty_read", bus2.data_out[11:6], 6'h2A);

    rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
    chk("rst2_err_clear", bus2.error, 2'b00);
    chk("rst2_dout", bus2.data_out, 12'h000);

    // 4-VC instance: each word lands only in its own FIFO.
    rst4_n = 1'b1;
    tick();
    push4(8'h11); push4(8'h52); push4(8'h93); push4(8'hD4); push4(8'h95);
    chk("vc4_empty", bus4.empty, 4'b0000);
    chk("vc4_ae", bus4.almost_empty, 4'b1011);
    chk("vc4_full", bus4.full, 4'b0000);
    bus4.pop = 4'b1111;
    tick();
    bus4.pop = 4'b0000;
    chk("vc4_dout", bus4.data_out, {8'hD4, 8'h93, 8'h52, 8'h11});
    chk("vc4_empty_after", bus4.empty, 4'b1011);

    push4(8'h16);
    rst4_n = 1'b0;
    bus4.wr_enable = 1'b1; bus4.data_in = 8'h57; bus4.pop = 4'b1111;
    tick();
    chk("vc4_rst_empty", bus4.empty, 4'b1111);
    chk("vc4_rst_dout", bus4.data_out, 32'h0);
    chk("vc4_rst_err", bus4.error, 4'b0000);
    rst4_n = 1'b1;
    bus4.wr_enable = 1'b0; bus4.pop = 4'b0000;
    tick();
    chk("vc4_rst_push_ignored", bus4.empty, 4'b1111);
    chk("vc4_rst_no_err", bus4.error, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
